// File: rtl/spi_shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_shift_engine: SPI master bit engine, 4 CPOL/CPHA modes, MSB first.      |
// | Optional SPI_WCOL_EN adds a write-collision pulse output.  Rev 1.0          |
// +----------------------------------------------------------------------------+
module spi_shift_engine #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             spi_enable,
    input  logic [3:0]       divisor,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic [WIDTH-1:0] rx_data,
    output logic             spi_done,
    output logic             busy,
    input  logic             spi_miso,
    output logic             spi_mosi,
`ifdef SPI_WCOL_EN
    output logic             wcol,
`endif
    output logic             spi_sck
);

    localparam int CW = $clog2(2 * WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tx_sr_q;
    logic [WIDTH-1:0] rx_sr_q;
    logic [WIDTH-1:0] rx_sr_d;
    logic [WIDTH-1:0] rx_data_q;
    logic [3:0]       pre_q;
    logic [3:0]       div_q;
    logic [CW-1:0]    edge_q;
    logic             cpol_q;
    logic             cpha_q;
    logic             done_q;
    logic             busy_q;
    logic             sck_q;

    logic w_wrap;
    logic w_sample;
    logic w_shift;
    logic w_last;

    // edge_q holds the number of edges already produced, so an even value
    // means the upcoming edge is a leading (odd-numbered) one.
    assign w_wrap   = (pre_q == div_q);
    assign w_sample = ~edge_q[0] ^ cpha_q;
    assign w_shift  = ~w_sample & ~(cpha_q & (edge_q == '0));
    assign w_last   = (edge_q == CW'(2 * WIDTH - 1));
    assign rx_sr_d  = {rx_sr_q[WIDTH-2:0], spi_miso};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            pre_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sck_q <= cpol;
                    // A write in the completion-pulse cycle is dropped.
                    if (tx_wr && spi_enable && !done_q) begin
                        tx_sr_q <= tx_data;
                        rx_sr_q <= '0;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        div_q   <= divisor;
                        pre_q   <= '0;
                        edge_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!spi_enable) begin
                        busy_q  <= 1'b0;
                        sck_q   <= cpol;
                        state_q <= ST_IDLE;
                    end else if (w_wrap) begin
                        pre_q  <= '0;
                        sck_q  <= ~sck_q;
                        edge_q <= edge_q + 1'b1;
                        if (w_sample) begin
                            rx_sr_q <= rx_sr_d;
                        end
                        if (w_shift) begin
                            tx_sr_q <= tx_sr_q << 1;
                        end
                        if (w_last) begin
                            rx_data_q <= w_sample ? rx_sr_d : rx_sr_q;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        pre_q <= pre_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_WCOL_EN
    logic wcol_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wcol_q <= 1'b0;
        end else begin
            wcol_q <= tx_wr & busy_q;
        end
    end

    assign wcol = wcol_q;
`endif

    assign rx_data  = rx_data_q;
    assign spi_done = done_q;
    assign busy     = busy_q;
    assign spi_mosi = tx_sr_q[WIDTH-1];
    assign spi_sck  = sck_q;

endmodule
`default_nettype wire
